seq_match_ctrl: RTL
===================

Name: seq_match_ctrl

Overview:
- Controller that feeds a serial pattern matcher from a parallel word stream: accepts words over a valid/ready handshake and shifts them out MSB-first, one bit per cycle, into an internal Mealy-style programmable matcher.
- Counts matches and raises an interrupt at a programmed threshold.
- Sits between a byte-wide producer and status/interrupt logic; replaces hard-coded single-pattern detectors with one runtime-configured engine.

Parameters:
- WORD_W, 8, input word width (bits shifted per accepted word)
- MAX_LEN, 8, maximum pattern length in bits
- CNT_W, 16, match counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  configuration write strobe; honoured only in IDLE
- cfg_pattern  in  MAX_LEN  pattern; bit 0 = last bit to arrive
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_thresh  in  CNT_W  irq threshold; 0 disables irq
- start  in  1  begin run (IDLE only)
- stop  in  1  request end of run
- in_valid  in  1  word available
- in_data  in  WORD_W  word; MSB shifted first
- in_ready  out  1  block can accept a word
- match_pulse  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  matches this run, saturating
- busy  out  1  high in WAIT or SHIFT
- done  out  1  one-cycle pulse on return to IDLE after stop
- irq  out  1  level; match_count >= cfg_thresh, thresh != 0

Behaviour:
- Reset (async, any state): state=IDLE. Clears config regs, shift register, history, fill counter and bit counter. All outputs 0.
- Config regs latch on cfg_we in IDLE; cfg_we outside IDLE is ignored.
  - Stored len = min(cfg_len, MAX_LEN).
  - Stored len 0: no match ever fires.
- FSM states: IDLE, WAIT, SHIFT.
- IDLE:
  - in_ready=0.
  - start -> WAIT; same edge clears match_count, history, fill counter, irq.
  - stop in IDLE is ignored.
- WAIT:
  - in_ready=1.
  - in_valid&&in_ready at edge T: word captured, bit counter=0, -> SHIFT.
  - stop pending (stop seen, or stop high this cycle) with no handshake this cycle -> IDLE, done pulse on entry cycle.
- SHIFT:
  - in_ready=0 (no word accepted while shifting).
  - Bit i (0..WORD_W-1, MSB first) enters history on edge T+1+i.
  - Fill counter increments, saturating at MAX_LEN.
  - After edge T+WORD_W: -> IDLE with done if stop pending, else -> WAIT.
  - Minimum word period WORD_W+1 cycles.
- stop:
  - Sampled and held as stop-pending in WAIT/SHIFT; the current word always completes.
  - Pending flag cleared on entering IDLE.
- Match evaluation (Mealy, on incoming bit b):
  - new_hist = {history, b}.
  - Match when fill+1 >= len and new_hist[len-1:0] == pattern[len-1:0].
  - match_pulse registered: high the cycle after the edge the bit entered, i.e. bit i -> pulse visible in cycle T+2+i (sampled at edge T+2+i).
- Non-overlap mode: on a match, fill counter resets to 0 and history bits are ignored until len new bits arrive. Overlap mode: fill unaffected.
- History persists across word boundaries within a run; patterns spanning two words are detected.
- match_count: +1 per match, registered with match_pulse, saturates at 2^CNT_W-1 (no wrap).
- irq: set when count >= thresh (thresh != 0), held until start or rst.
- Simultaneous cfg_we and start in IDLE: config latches and the run starts on the same edge; the run uses the new config.
- done and match_pulse may coincide on the final bit.

Test Plan:
- Overlap: pattern 4'b1011, len 4, overlap=1; word 8'b10110110 accepted at edge T -> match_pulse in cycles T+5 and T+8; match_count=2.
- Non-overlap: same word, overlap=0 -> single pulse at T+5; match_count=1.
- Boundary span: len 4, pattern 1011; words 8'b00000101 then 8'b10000000 -> exactly one match, from word2 bit 0 (pulse 2 cycles after its handshake); count=1.
- Handshake/stop:
  - in_valid held high -> in_ready high only in WAIT, one word per 9 cycles (WORD_W=8).
  - stop asserted mid-SHIFT -> remaining bits still shifted, then done pulse; busy=0, in_ready=0.
- Saturation/irq: CNT_W=2, pattern 1'b1, len 1, thresh 2; word 8'hFF -> 8 match pulses; count goes 1,2,3 then holds 3; irq rises with count=2; next start clears count and irq.
- Reset/config guard:
  - rst asserted mid-SHIFT -> all outputs 0 immediately (async), state IDLE.
  - cfg_we during WAIT -> config unchanged.
  - len 0 -> zero matches on any data.

Source files
------------

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: takes parallel words over a valid/ready handshake, shifts
// them MSB-first into a runtime-programmable serial pattern matcher, counts
// matches (saturating) and raises a level interrupt at a programmed threshold.
module seq_match_ctrl #(
    parameter int WORD_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1),
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    output logic               in_ready,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               irq
);

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   thr_q;
    logic [WORD_W-1:0]  shreg;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [BIT_W-1:0]   bit_cnt;
    logic               stop_pend;

    logic               bit_in;
    logic [MAX_LEN-1:0] new_hist;
    logic               fill_ok;
    logic               hit;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               stop_now;
    logic               last_bit;

    // Ones in the low 'len' positions; selects the pattern bits that take part.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        for (int k = 0; k < MAX_LEN; k++) begin
            m[k] = (k < int'(len));
        end
        return m;
    endfunction

    // Programmed length is clamped so an oversize value still means "full width".
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (int'(len) > MAX_LEN) ? LEN_W'(MAX_LEN) : len;
    endfunction

    // Match counter never wraps; it sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Fill counter tracks valid history depth, capped at the longest pattern.
    function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] f);
        return (int'(f) >= MAX_LEN) ? LEN_W'(MAX_LEN) : f + LEN_W'(1);
    endfunction

    // Mealy match on the bit entering history this cycle.
    always_comb begin
        bit_in   = shreg[WORD_W-1];
        new_hist = {hist[MAX_LEN-2:0], bit_in};
        fill_ok  = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len_q};
        hit      = (state == SHIFT) && (len_q != '0) && fill_ok &&
                   (((new_hist ^ pat_q) & len_mask(len_q)) == '0);
        cnt_nxt  = sat_inc(match_count);
        stop_now = stop_pend | stop;
        last_bit = (bit_cnt == BIT_W'(WORD_W - 1));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            thr_q       <= '0;
            shreg       <= '0;
            hist        <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
            stop_pend   <= 1'b0;
            in_ready    <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            irq         <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pat_q <= cfg_pattern;
                        len_q <= clamp_len(cfg_len);
                        ovl_q <= cfg_overlap;
                        thr_q <= cfg_thresh;
                    end
                    if (start) begin
                        state       <= WAIT;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        match_count <= '0;
                        hist        <= '0;
                        fill        <= '0;
                        irq         <= 1'b0;
                        stop_pend   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
                        stop_pend <= stop_now;
                    end else if (stop_now) begin
                        state     <= IDLE;
                        in_ready  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        stop_pend <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg       <= shreg << 1;
                    hist        <= new_hist;
                    fill        <= (hit && !ovl_q) ? '0 : fill_inc(fill);
                    match_pulse <= hit;
                    if (hit) begin
                        match_count <= cnt_nxt;
                        if ((thr_q != '0) && (cnt_nxt >= thr_q)) begin
                            irq <= 1'b1;
                        end
                    end
                    if (last_bit) begin
                        if (stop_now) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                        end else begin
                            state     <= WAIT;
                            in_ready  <= 1'b1;
                            stop_pend <= 1'b0;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                        stop_pend <= stop_now;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
